zap_wb_sram_ctrl: RTL and testbench
===================================

# zap_wb_sram_ctrl

Wishbone B3 slave that terminates the processor's external bus in an on-chip single-port synchronous SRAM. It sits directly downstream of the top-level `o_wb_*` master port. It accepts classic and incrementing-burst (linear) cycles, with cache-line refills and store-buffer write bursts sustaining one beat per cycle. It generates the SRAM address internally during bursts and handles out-of-range accesses and aborted cycles.

## Interface
- `ADDR_WIDTH`, 14: SRAM word-address width; capacity 4·2^ADDR_WIDTH bytes.
- `BASE_ADDR`, 32'h0000_0000: byte base address, aligned to 4·2^ADDR_WIDTH.
- `i_clk` in 1: single clock.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1 each: Wishbone cycle, strobe and write enable.
- `i_wb_adr` in 32: byte address; bits [1:0] ignored.
- `i_wb_dat` in 32: write data.
- `i_wb_sel` in 4: byte enables.
- `i_wb_cti` in 3: cycle type; 000 classic, 001 constant, 010 incrementing, 111 end.
- `i_wb_bte` in 2: burst type; all values treated as linear.
- `o_wb_ack` out 1: beat acknowledge.
- `o_wb_dat` out 32: read data.
- `o_mem_en` out 1: SRAM access enable.
- `o_mem_we` out 4: SRAM byte write enables.
- `o_mem_adr` out ADDR_WIDTH: SRAM word address.
- `o_mem_wdat` out 32: SRAM write data, equal to `i_wb_dat`.
- `i_mem_rdat` in 32: SRAM read data, valid one cycle after the `o_mem_en` edge.
- `o_bad_access` out 1: one-cycle pulse on an acked out-of-range first beat.

## Operation
- States: IDLE, READ, WRITE, DONE.
- `req` = `i_wb_cyc & i_wb_stb`.
- `hit` = (`i_wb_adr[31:ADDR_WIDTH+2]` == `BASE_ADDR[31:ADDR_WIDTH+2]`). `hit` is evaluated on the first beat only and latched in `hit_q`.
- Word address is `i_wb_adr[ADDR_WIDTH+1:2]`. Counter `adr_q` holds the current beat address.
- Next address: cti 010 gives `adr_q+1` mod 2^ADDR_WIDTH, so a burst wraps within the SRAM. Any other cti leaves `adr_q` unchanged.
- IDLE:
  - `o_mem_adr` follows the input word address.
  - On `req & !we`, assert `o_mem_en` when `hit`, load `adr_q`, and go to READ.
  - On `req & we`, load `adr_q` and go to WRITE.
  - Without `req`, stay in IDLE with all strobes 0.
- READ, beat cycle:
  - If `req`: `o_wb_ack`=1 and `o_wb_dat` = `hit_q ? i_mem_rdat : 0`.
  - If cti=010 or 001: issue the next address with `o_mem_en` = `hit_q`, update `adr_q`, stay in READ.
  - Otherwise (000 or 111) go to DONE.
- WRITE, beat cycle:
  - If `req`: `o_wb_ack`=1, `o_mem_en` = `hit_q`, `o_mem_we` = `hit_q ? i_wb_sel : 0`, `o_mem_adr` = `adr_q`.
  - Continue or terminate on cti exactly as in READ.
- READ/WRITE with `i_wb_cyc`=1 and `i_wb_stb`=0: wait state. No ack, no SRAM access, `adr_q` held. In READ, re-issue `adr_q` with `o_mem_en` so the data is valid when `stb` returns.
- READ/WRITE with `i_wb_cyc`=0: abort. Go to IDLE with no ack and no write.
- DONE: one bubble cycle with no ack and no request accepted, then IDLE. This prevents double-acking a classic master that has not yet dropped `stb`.
- `o_bad_access`=1 in the cycle of the first ack when `hit_q`=0.
- `o_wb_dat`=0 outside READ-ack cycles.

## Timing
- Reset values: state IDLE, `adr_q`=0, `hit_q`=0. `o_wb_ack`, `o_mem_en`, `o_mem_we`, `o_bad_access` and `o_wb_dat` are all 0. `o_mem_adr` follows `i_wb_adr`.
- Reset during a burst: IDLE on the next edge, with no further ack or SRAM write.
- Latency: the first ack comes 1 cycle after `req` is sampled in IDLE, for both reads and writes.
- Burst throughput is 1 beat/cycle. An N-beat burst occupies N+1 cycles, plus 1 DONE cycle.
- Classic back-to-back cycles: 3 cycles per access (request, ack, DONE).
- Ack is combinational from `req` within READ/WRITE. The SRAM write takes effect on the ack edge.
- The SRAM read address is registered by the SRAM on the edge before the ack cycle.

## Test plan
- Classic write then read: write 0xDEADBEEF to 0x10, sel=1111, then read 0x10. Ack arrives 1 cycle after each request and the read returns 0xDEADBEEF; DONE bubble observed.
- 16-beat incrementing read from 0x40 (cti 010…, last 111) over preloaded word pattern i: 16 consecutive acks with data 0x10..0x1F, then DONE, then IDLE.
- Write burst wrap: 4 beats from byte address 4·(2^ADDR_WIDTH−2). The burst writes words 2^AW−2, 2^AW−1, 0 and 1; readback matches.
- Byte enables and wait states: sel=0010 with data 0xAABBCCDD over 0x00000000 writes byte1 only, giving 0x0000CC00. A `stb` drop mid read burst stalls with no ack, holds the address, and resumes with correct data.
- Out-of-range: read at BASE_ADDR+4·2^ADDR_WIDTH acks with data 0 and pulses `o_bad_access`. A write to the same address leaves `o_mem_we`=0 and the SRAM unchanged.
- Abort and reset: drop `cyc` after beat 2 of an 8-beat write, which must return to IDLE with beats 3–8 not written. Assert `i_reset` mid read burst: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/zap_wb_sram_ctrl.sv
// Wishbone B3 slave bridging classic and linear-burst cycles onto a single-port
// synchronous SRAM, with internal burst address generation and out-of-range flagging.
module zap_wb_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [31:0]           i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  input  logic [3:0]            i_wb_sel,
  input  logic [2:0]            i_wb_cti,
  input  logic [1:0]            i_wb_bte,
  output logic                  o_wb_ack,
  output logic [31:0]           o_wb_dat,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_adr,
  output logic [31:0]           o_mem_wdat,
  input  logic [31:0]           i_mem_rdat,
  output logic                  o_bad_access
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d, adr_next;
  logic                  hit_q, hit_d;
  logic                  first_q, first_d;
  logic                  req, hit, cont;
  logic [ADDR_WIDTH-1:0] in_adr;
  logic                  unused_ok;

  // Byte-lane bits and burst type do not affect a linear word-addressed SRAM.
  assign unused_ok = ^{i_wb_bte, i_wb_adr[1:0]};

  assign req        = i_wb_cyc & i_wb_stb;
  assign hit        = (i_wb_adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign in_adr     = i_wb_adr[ADDR_WIDTH+1:2];
  assign cont       = (i_wb_cti == 3'b010) || (i_wb_cti == 3'b001);
  assign adr_next   = (i_wb_cti == 3'b010) ? adr_q + ADDR_WIDTH'(1) : adr_q;
  assign o_mem_wdat = i_wb_dat;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      hit_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      hit_q   <= hit_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    hit_d        = hit_q;
    first_d      = first_q;
    o_wb_ack     = 1'b0;
    o_wb_dat     = '0;
    o_mem_en     = 1'b0;
    o_mem_we     = '0;
    o_mem_adr    = adr_q;
    o_bad_access = 1'b0;
    case (state_q)
      IDLE: begin
        o_mem_adr = in_adr;
        if (req) begin
          adr_d   = in_adr;
          hit_d   = hit;
          first_d = 1'b1;
          if (i_wb_we) begin
            state_d = WRITE;
          end else begin
            o_mem_en = hit;
            state_d  = READ;
          end
        end
      end
      READ: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (!i_wb_stb) begin
          // Keep the SRAM output pointing at the pending beat across the stall.
          o_mem_en = hit_q;
        end else begin
          o_wb_ack     = 1'b1;
          o_wb_dat     = hit_q ? i_mem_rdat : 32'h0;
          o_bad_access = first_q & ~hit_q;
          first_d      = 1'b0;
          if (cont) begin
            adr_d     = adr_next;
            o_mem_adr = adr_next;
            o_mem_en  = hit_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (i_wb_stb) begin
          o_wb_ack     = 1'b1;
          o_mem_en     = hit_q;
          o_mem_we     = hit_q ? i_wb_sel : 4'b0000;
          o_bad_access = first_q & ~hit_q;
          first_d      = 1'b0;
          if (cont) adr_d = adr_next;
          else      state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_zap_wb_sram_ctrl.sv
// Randomized and directed bench for zap_wb_sram_ctrl against a word-array
// reference memory and per-beat expectations derived from the bus protocol.
module tb_zap_wb_sram_ctrl;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]   i_wb_adr, i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic [2:0]    i_wb_cti;
  logic [1:0]    i_wb_bte;
  logic          o_wb_ack;
  logic [31:0]   o_wb_dat;
  logic          o_mem_en;
  logic [3:0]    o_mem_we;
  logic [AW-1:0] o_mem_adr;
  logic [31:0]   o_mem_wdat;
  logic [31:0]   i_mem_rdat;
  logic          o_bad_access;

  logic [31:0] sram    [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] wdata   [0:15];
  logic        preload;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  zap_wb_sram_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_cti(i_wb_cti), .i_wb_bte(i_wb_bte),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_adr(o_mem_adr),
    .o_mem_wdat(o_mem_wdat), .i_mem_rdat(i_mem_rdat),
    .o_bad_access(o_bad_access)
  );

  // Single-port synchronous SRAM: registered read of the old contents.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= i;
    end else if (o_mem_en) begin
      for (int k = 0; k < 4; k++)
        if (o_mem_we[k]) sram[o_mem_adr][8*k +: 8] <= o_mem_wdat[8*k +: 8];
      i_mem_rdat <= sram[o_mem_adr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One Wishbone transaction of n beats. stall_beat inserts one stb-low cycle
  // before that beat; cut_after ends the cycle before that beat by dropping
  // cyc (abort) or pulsing i_reset.
  task automatic do_xfer(input bit we, input logic [31:0] badr, input int n,
                         input logic [3:0] sel, input int stall_beat,
                         input int cut_after, input bit cut_reset);
    bit          hit;
    int          w0, w;
    logic [31:0] exp;
    hit = ((badr >> (AW + 2)) == (BASE >> (AW + 2)));
    w0  = int'((badr >> 2) % DEPTH);
    $display("xfer we=%0d adr=%h beats=%0d sel=%b stall=%0d cut=%0d rst=%0d",
             we, badr, n, sel, stall_beat, cut_after, cut_reset);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_adr = badr;
    i_wb_sel = sel; i_wb_dat = wdata[0];
    i_wb_cti = (n == 1) ? 3'b000 : 3'b010;
    @(negedge clk);
    check_eq("req_noack", 32'(o_wb_ack), 0);
    if (!we) check_eq("req_rd_en", 32'(o_mem_en), 32'(hit));
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      w = (w0 + b) % DEPTH;
      if (b == cut_after) begin
        if (cut_reset) begin
          i_reset = 1;
          @(posedge clk); #1;
          i_reset = 0; i_wb_stb = 0;
          @(negedge clk);
          check_eq("rst_ack", 32'(o_wb_ack), 0);
          check_eq("rst_en", 32'(o_mem_en), 0);
          check_eq("rst_we", 32'(o_mem_we), 0);
          check_eq("rst_dat", o_wb_dat, 0);
          check_eq("rst_bad", 32'(o_bad_access), 0);
          @(posedge clk); #1;
        end else begin
          i_wb_cyc = 0; i_wb_stb = 0;
          @(negedge clk);
          check_eq("abort_ack", 32'(o_wb_ack), 0);
          check_eq("abort_we", 32'(o_mem_we), 0);
          @(posedge clk); #1;
        end
        i_wb_cyc = 0; i_wb_stb = 0;
        @(posedge clk); #1;
        return;
      end
      if (b == stall_beat) begin
        i_wb_stb = 0;
        @(negedge clk);
        check_eq("stall_ack", 32'(o_wb_ack), 0);
        if (we) check_eq("stall_we", 32'(o_mem_we), 0);
        else begin
          check_eq("stall_en", 32'(o_mem_en), 32'(hit));
          check_eq("stall_adr", 32'(o_mem_adr), 32'(w));
        end
        @(posedge clk); #1;
      end
      i_wb_stb = 1; i_wb_adr = badr + 32'(4 * b); i_wb_dat = wdata[b];
      i_wb_cti = (b == n - 1) ? ((n == 1) ? 3'b000 : 3'b111) : 3'b010;
      @(negedge clk);
      check_eq("beat_ack", 32'(o_wb_ack), 1);
      check_eq("beat_bad", 32'(o_bad_access), 32'(b == 0 && !hit));
      if (we) begin
        check_eq("wr_we", 32'(o_mem_we), hit ? 32'(sel) : 0);
        check_eq("wr_adr", 32'(o_mem_adr), 32'(w));
        if (hit)
          for (int k = 0; k < 4; k++)
            if (sel[k]) ref_mem[w][8*k +: 8] = wdata[b][8*k +: 8];
      end else begin
        exp = hit ? ref_mem[w] : 32'h0;
        check_eq("rd_dat", o_wb_dat, exp);
      end
      @(posedge clk); #1;
    end
    // Master still holding stb: the bubble cycle must not ack again.
    @(negedge clk);
    check_eq("done_ack", 32'(o_wb_ack), 0);
    check_eq("done_dat", o_wb_dat, 0);
    check_eq("done_en", 32'(o_mem_en), 0);
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_cti = 3'b000;
    @(negedge clk);
    check_eq("idle_ack", 32'(o_wb_ack), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          rwe, oor;
    int          rn;
    logic [31:0] radr;
    i_reset = 1; preload = 1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = 32'h0000_1234;
    i_wb_dat = 0; i_wb_sel = 0; i_wb_cti = 0; i_wb_bte = 2'b01;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_ack0", 32'(o_wb_ack), 0);
    check_eq("rst_en0", 32'(o_mem_en), 0);
    check_eq("rst_we0", 32'(o_mem_we), 0);
    check_eq("rst_bad0", 32'(o_bad_access), 0);
    check_eq("rst_dat0", o_wb_dat, 0);
    check_eq("rst_adr0", 32'(o_mem_adr), 32'h8D);
    @(posedge clk); #1;
    i_reset = 0; preload = 0;
    @(posedge clk); #1;

    wdata[0] = 32'hDEADBEEF;
    do_xfer(1, 32'h10, 1, 4'hF, -1, -1, 0);
    do_xfer(0, 32'h10, 1, 4'hF, -1, -1, 0);
    do_xfer(0, 32'h40, 16, 4'hF, -1, -1, 0);
    wdata[0] = 32'hAABBCCDD;
    do_xfer(1, 32'h0, 1, 4'b0010, -1, -1, 0);
    do_xfer(0, 32'h0, 1, 4'hF, -1, -1, 0);
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_xfer(1, 32'(4 * (DEPTH - 2)), 4, 4'hF, -1, -1, 0);
    do_xfer(0, 32'(4 * (DEPTH - 2)), 4, 4'hF, -1, -1, 0);
    do_xfer(0, 32'h80, 8, 4'hF, 3, -1, 0);
    do_xfer(0, 32'(4 * DEPTH), 1, 4'hF, -1, -1, 0);
    wdata[0] = 32'h1234_5678;
    do_xfer(1, 32'(4 * DEPTH), 1, 4'hF, -1, -1, 0);
    do_xfer(0, 32'h0, 1, 4'hF, -1, -1, 0);
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    do_xfer(1, 32'h200, 8, 4'hF, -1, 2, 0);
    do_xfer(0, 32'h200, 8, 4'hF, -1, -1, 0);
    do_xfer(0, 32'h300, 8, 4'hF, -1, 3, 1);
    do_xfer(0, 32'h300, 1, 4'hF, -1, -1, 0);

    for (int t = 0; t < 30; t++) begin
      rwe  = 1'($urandom_range(0, 1));
      rn   = $urandom_range(1, 6);
      oor  = ($urandom_range(0, 5) == 0);
      radr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (oor) radr = radr + 32'($urandom_range(1, 255)) * 32'(4 * DEPTH);
      for (int i = 0; i < rn; i++) wdata[i] = $urandom;
      do_xfer(rwe, radr, rn, 4'($urandom_range(0, 15)), $urandom_range(0, rn), -1, 0);
    end
    for (int i = 0; i < 4; i++) do_xfer(0, 32'(i * 64 * 4), 16, 4'hF, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
